// File: rtl/mrna_iso_sequencer_if.sv
// Host-side command/status and control-line bundle of the mRNA isolation sequencer.
// master = host / line-driver side, slave = sequencer.
interface mrna_iso_sequencer_if;
    logic       start;
    logic       abort;
    logic       busy;
    logic       done;
    logic [3:0] state;
    logic       cells_in_ctl;
    logic       cells_out_ctl;
    logic       collect_ctl;
    logic       lysis_in_ctl;
    logic       lysis_waste_ctl;
    logic       beads_in_ctl;
    logic       bead_waste_ctl;
    logic       push_ctl;
    logic       sep_ctl;
    logic       sieve_ctl;
    logic       waste_ctl;
    logic       pump_1;
    logic       pump_2;
    logic       pump_3;

    modport master (
        output start, abort,
        input  busy, done, state,
        input  cells_in_ctl, cells_out_ctl, collect_ctl, lysis_in_ctl, lysis_waste_ctl,
        input  beads_in_ctl, bead_waste_ctl, push_ctl, sep_ctl, sieve_ctl, waste_ctl,
        input  pump_1, pump_2, pump_3
    );

    modport slave (
        input  start, abort,
        output busy, done, state,
        output cells_in_ctl, cells_out_ctl, collect_ctl, lysis_in_ctl, lysis_waste_ctl,
        output beads_in_ctl, bead_waste_ctl, push_ctl, sep_ctl, sieve_ctl, waste_ctl,
        output pump_1, pump_2, pump_3
    );
endinterface

// File: rtl/mrna_iso_sequencer.sv
// Timed protocol sequencer for the 3-lane mRNA isolation array: walks the valve/pump lines
// through load, lyse, mix, capture, separate, wash and collect, with an abort/flush path.
module mrna_iso_sequencer #(
    parameter int unsigned TICK_DIV   = 1000,
    parameter int unsigned CW         = 16,
    parameter int unsigned T_LOAD     = 8,
    parameter int unsigned T_LYSIS    = 4,
    parameter int unsigned MIX_CYCLES = 20,
    parameter int unsigned T_BEADS    = 4,
    parameter int unsigned T_SEP      = 6,
    parameter int unsigned T_WASH     = 4,
    parameter int unsigned T_COLLECT  = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    mrna_iso_sequencer_if.slave  bus
);
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD    = 4'd1,
        ST_LYSIS   = 4'd2,
        ST_MIX     = 4'd3,
        ST_BEADS   = 4'd4,
        ST_SEP     = 4'd5,
        ST_WASH    = 4'd6,
        ST_COLLECT = 4'd7,
        ST_FLUSH   = 4'd8,
        ST_DONE    = 4'd9
    } state_e;

    localparam int unsigned TD = (TICK_DIV == 32'd0) ? 32'd1 : TICK_DIV;
    localparam int unsigned PW = (TD > 32'd1) ? $clog2(TD) : 32'd1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TD - 32'd1);
    localparam int unsigned MIX_TICKS = ((MIX_CYCLES == 32'd0) ? 32'd1 : MIX_CYCLES) * 32'd6;

    // Line vector bit positions; pumps occupy [2:0] as {pump_1, pump_2, pump_3}.
    localparam int unsigned B_CELLS_IN    = 13;
    localparam int unsigned B_CELLS_OUT   = 12;
    localparam int unsigned B_COLLECT     = 11;
    localparam int unsigned B_LYSIS_IN    = 10;
    localparam int unsigned B_LYSIS_WASTE = 9;
    localparam int unsigned B_BEADS_IN    = 8;
    localparam int unsigned B_BEAD_WASTE  = 7;
    localparam int unsigned B_PUSH        = 6;
    localparam int unsigned B_SEP         = 5;
    localparam int unsigned B_SIEVE       = 4;
    localparam int unsigned B_WASTE       = 3;

    function automatic logic [CW-1:0] last_tick(input int unsigned t);
        last_tick = (t == 32'd0) ? {CW{1'b0}} : CW'(t - 32'd1);
    endfunction

    localparam logic [CW-1:0] LAST_LOAD    = last_tick(T_LOAD);
    localparam logic [CW-1:0] LAST_LYSIS   = last_tick(T_LYSIS);
    localparam logic [CW-1:0] LAST_MIX     = last_tick(MIX_TICKS);
    localparam logic [CW-1:0] LAST_BEADS   = last_tick(T_BEADS);
    localparam logic [CW-1:0] LAST_SEP     = last_tick(T_SEP);
    localparam logic [CW-1:0] LAST_WASH    = last_tick(T_WASH);
    localparam logic [CW-1:0] LAST_COLLECT = last_tick(T_COLLECT);

    function automatic state_e next_step(input state_e s);
        case (s)
            ST_LOAD:    next_step = ST_LYSIS;
            ST_LYSIS:   next_step = ST_MIX;
            ST_MIX:     next_step = ST_BEADS;
            ST_BEADS:   next_step = ST_SEP;
            ST_SEP:     next_step = ST_WASH;
            ST_WASH:    next_step = ST_COLLECT;
            ST_COLLECT: next_step = ST_DONE;
            default:    next_step = ST_IDLE;
        endcase
    endfunction

    function automatic logic [2:0] pump_pattern(input logic [2:0] ph);
        case (ph)
            3'd0:    pump_pattern = 3'b011;
            3'd1:    pump_pattern = 3'b001;
            3'd2:    pump_pattern = 3'b101;
            3'd3:    pump_pattern = 3'b100;
            3'd4:    pump_pattern = 3'b110;
            3'd5:    pump_pattern = 3'b010;
            default: pump_pattern = 3'b111;
        endcase
    endfunction

    state_e          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      phase_q, phase_d;
    logic [13:0]     lines_q, lines_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tick_s;
    logic            last_s;

    // State register plus registered outputs; reset closes every line immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            presc_q <= {PW{1'b0}};
            cnt_q   <= {CW{1'b0}};
            phase_q <= 3'd0;
            lines_q <= 14'h3FFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            lines_q <= lines_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next-state: abort beats a coinciding final tick, start only counts in IDLE.
    always_comb begin
        tick_s  = (presc_q == PRESC_LAST);
        state_d = state_q;
        case (state_q)
            ST_LOAD:    last_s = (cnt_q == LAST_LOAD);
            ST_LYSIS:   last_s = (cnt_q == LAST_LYSIS);
            ST_MIX:     last_s = (cnt_q == LAST_MIX);
            ST_BEADS:   last_s = (cnt_q == LAST_BEADS);
            ST_SEP:     last_s = (cnt_q == LAST_SEP);
            ST_WASH:    last_s = (cnt_q == LAST_WASH);
            ST_COLLECT: last_s = (cnt_q == LAST_COLLECT);
            ST_FLUSH:   last_s = (cnt_q == LAST_WASH);
            default:    last_s = 1'b0;
        endcase
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_LOAD;
                else           state_d = ST_IDLE;
            end
            ST_LOAD, ST_LYSIS, ST_MIX, ST_BEADS, ST_SEP, ST_WASH, ST_COLLECT: begin
                if (bus.abort)             state_d = ST_FLUSH;
                else if (tick_s && last_s) state_d = next_step(state_q);
                else                       state_d = state_q;
            end
            ST_FLUSH: begin
                if (tick_s && last_s) state_d = ST_IDLE;
                else                  state_d = ST_FLUSH;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Timebase: prescaler, dwell counter and pump phase restart on every state entry.
    always_comb begin
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            presc_d = {PW{1'b0}};
            cnt_d   = {CW{1'b0}};
            phase_d = 3'd0;
        end else if (tick_s) begin
            presc_d = {PW{1'b0}};
            cnt_d   = cnt_q + {{(CW-1){1'b0}}, 1'b1};
            phase_d = (phase_q == 3'd5) ? 3'd0 : (phase_q + 3'd1);
        end else begin
            presc_d = presc_q + {{(PW-1){1'b0}}, 1'b1};
            cnt_d   = cnt_q;
            phase_d = phase_q;
        end
    end

    // Output decode from the upcoming state so lines only move with a transition or phase step.
    always_comb begin
        lines_d = 14'h3FFF;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_d == ST_DONE);
        case (state_d)
            ST_LOAD:    begin lines_d[B_CELLS_IN] = 1'b0; lines_d[B_CELLS_OUT]   = 1'b0; end
            ST_LYSIS:   begin lines_d[B_LYSIS_IN] = 1'b0; lines_d[B_LYSIS_WASTE] = 1'b0; end
            ST_MIX:     lines_d[2:0] = pump_pattern(phase_d);
            ST_BEADS:   begin lines_d[B_BEADS_IN] = 1'b0; lines_d[B_BEAD_WASTE]  = 1'b0; end
            ST_SEP:     begin lines_d[B_SEP]      = 1'b0; lines_d[B_PUSH]        = 1'b0; end
            ST_WASH:    begin lines_d[B_WASTE]    = 1'b0; lines_d[B_SIEVE]       = 1'b0; end
            ST_COLLECT: begin lines_d[B_COLLECT]  = 1'b0; lines_d[B_PUSH]        = 1'b0; end
            ST_FLUSH:   begin lines_d[B_WASTE]    = 1'b0; lines_d[B_CELLS_OUT]   = 1'b0; end
            default:    lines_d = 14'h3FFF;
        endcase
    end

    assign bus.state           = state_q;
    assign bus.busy            = busy_q;
    assign bus.done            = done_q;
    assign bus.cells_in_ctl    = lines_q[B_CELLS_IN];
    assign bus.cells_out_ctl   = lines_q[B_CELLS_OUT];
    assign bus.collect_ctl     = lines_q[B_COLLECT];
    assign bus.lysis_in_ctl    = lines_q[B_LYSIS_IN];
    assign bus.lysis_waste_ctl = lines_q[B_LYSIS_WASTE];
    assign bus.beads_in_ctl    = lines_q[B_BEADS_IN];
    assign bus.bead_waste_ctl  = lines_q[B_BEAD_WASTE];
    assign bus.push_ctl        = lines_q[B_PUSH];
    assign bus.sep_ctl         = lines_q[B_SEP];
    assign bus.sieve_ctl       = lines_q[B_SIEVE];
    assign bus.waste_ctl       = lines_q[B_WASTE];
    assign bus.pump_1          = lines_q[2];
    assign bus.pump_2          = lines_q[1];
    assign bus.pump_3          = lines_q[0];
endmodule

// File: tb/tb_mrna_iso_sequencer.sv
// Randomized scoreboard bench: each run's expected output segments (state, lines, dwell)
// are queued from a protocol model; a negedge monitor pops one per observed output change.
module tb_mrna_iso_sequencer;
    localparam int TD = 4, T_LOAD = 2, T_LYSIS = 1, MC = 1, T_BEADS = 1;
    localparam int T_SEP = 1, T_WASH = 2, T_COLLECT = 1;
    localparam int RUN_CLK = (T_LOAD + T_LYSIS + 6 * MC + T_BEADS + T_SEP + T_WASH + T_COLLECT) * TD + 1;
    localparam logic [2:0] PUMP_SEQ [6] = '{3'b011, 3'b001, 3'b101, 3'b100, 3'b110, 3'b010};

    typedef struct {
        logic [19:0] tup;
        int          len;
    } seg_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0, n_fail = 0, n_done_seen = 0, n_done_exp = 0;
    logic mon_en = 1'b0;
    seg_t exp_q[$];
    seg_t plan[$];

    mrna_iso_sequencer_if bus();

    mrna_iso_sequencer #(
        .TICK_DIV(TD), .CW(16), .T_LOAD(T_LOAD), .T_LYSIS(T_LYSIS), .MIX_CYCLES(MC),
        .T_BEADS(T_BEADS), .T_SEP(T_SEP), .T_WASH(T_WASH), .T_COLLECT(T_COLLECT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    logic [19:0] obs_s;
    assign obs_s = {bus.state, bus.busy, bus.done,
                    bus.cells_in_ctl, bus.cells_out_ctl, bus.collect_ctl, bus.lysis_in_ctl,
                    bus.lysis_waste_ctl, bus.beads_in_ctl, bus.bead_waste_ctl, bus.push_ctl,
                    bus.sep_ctl, bus.sieve_ctl, bus.waste_ctl, bus.pump_1, bus.pump_2, bus.pump_3};

    // Open valves per protocol step; everything else stays pressurised (1).
    function automatic logic [13:0] lines_for(input int st, input logic [2:0] pump);
        logic [13:0] l;
        l = 14'h3FFF;
        case (st)
            1: begin l[13] = 1'b0; l[12] = 1'b0; end // cells_in, cells_out
            2: begin l[10] = 1'b0; l[9]  = 1'b0; end // lysis_in, lysis_waste
            3: l[2:0] = pump;
            4: begin l[8]  = 1'b0; l[7]  = 1'b0; end // beads_in, bead_waste
            5: begin l[5]  = 1'b0; l[6]  = 1'b0; end // sep, push
            6: begin l[3]  = 1'b0; l[4]  = 1'b0; end // waste, sieve
            7: begin l[11] = 1'b0; l[6]  = 1'b0; end // collect, push
            8: begin l[3]  = 1'b0; l[12] = 1'b0; end // waste, cells_out
            default: l = 14'h3FFF;
        endcase
        return l;
    endfunction

    function automatic logic [19:0] tup(input int st, input logic [2:0] pump);
        logic [3:0] s4;
        s4 = 4'(st);
        return {s4, (st != 0), (st == 9), lines_for(st, pump)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_seg(input int st, input logic [2:0] pump, input int len);
        seg_t s;
        s.tup = tup(st, pump);
        s.len = len;
        plan.push_back(s);
    endtask

    task automatic plan_run();
        plan.delete();
        add_seg(1, 3'b111, T_LOAD * TD);
        add_seg(2, 3'b111, T_LYSIS * TD);
        for (int p = 0; p < 6 * MC; p++) add_seg(3, PUMP_SEQ[p % 6], TD);
        add_seg(4, 3'b111, T_BEADS * TD);
        add_seg(5, 3'b111, T_SEP * TD);
        add_seg(6, 3'b111, T_WASH * TD);
        add_seg(7, 3'b111, T_COLLECT * TD);
        add_seg(9, 3'b111, 1);
    endtask

    // Scoreboard monitor: every change of the observed output tuple starts a new segment.
    logic [19:0] prev_obs;
    seg_t        cur;
    int          run_len = 0;
    bit          have_cur = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            if (obs_s !== prev_obs) begin
                if (have_cur && cur.len != 0) chk("segment_len", run_len, cur.len);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    have_cur = 1'b0;
                    $display("FAIL unexpected_change: got 0x%0h, nothing expected", obs_s);
                end else begin
                    cur = exp_q.pop_front();
                    have_cur = 1'b1;
                    chk("segment_outputs", obs_s, cur.tup);
                end
                run_len = 1;
            end else begin
                run_len++;
            end
            if (bus.done === 1'b1) n_done_seen++;
            prev_obs = obs_s;
        end
    end

    task automatic run_one(input int r);
        int abort_j, noise_j, last_j, cum, done_j;
        bit aborted;
        seg_t s;
        repeat ($urandom_range(1, 4)) @(negedge clk);
        if ($urandom_range(0, 1) == 1) begin
            bus.abort = 1'b1;
            @(negedge clk);
            bus.abort = 1'b0;
        end
        if (r == 0)                        abort_j = -1;
        else if (r == 1)                   abort_j = (T_LOAD + T_LYSIS) * TD + 3 * TD + 1; // MIX phase 3
        else if ($urandom_range(0, 1) == 0) abort_j = -1;
        else                               abort_j = $urandom_range(0, RUN_CLK + 3);
        plan_run();
        cum = 0;
        aborted = 1'b0;
        foreach (plan[i]) begin
            if (!aborted) begin
                if (abort_j >= cum && abort_j < cum + plan[i].len && plan[i].tup[19:16] != 4'd9) begin
                    s.tup = plan[i].tup;
                    s.len = abort_j - cum + 1;
                    exp_q.push_back(s);
                    s.tup = tup(8, 3'b111);
                    s.len = T_WASH * TD;
                    exp_q.push_back(s);
                    aborted = 1'b1;
                end else begin
                    exp_q.push_back(plan[i]);
                    cum += plan[i].len;
                end
            end
        end
        s.tup = tup(0, 3'b111);
        s.len = 0;
        exp_q.push_back(s);
        last_j = aborted ? abort_j + T_WASH * TD : cum - 1;
        if (!aborted) n_done_exp++;
        noise_j = $urandom_range(1, last_j);
        done_j = -1;

        bus.start = 1'b1;
        bus.abort = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        for (int j = 0; j <= last_j + 2; j++) begin
            if (bus.done === 1'b1 && done_j < 0) done_j = j;
            bus.start = (j == noise_j);
            bus.abort = (j == abort_j) || (aborted && j == abort_j + 3);
            @(negedge clk);
        end
        bus.start = 1'b0;
        bus.abort = 1'b0;
        if (aborted) chk("no_done_on_abort", done_j, -1);
        else         chk("start_to_done_clk", done_j + 1, RUN_CLK);
    endtask

    task automatic reset_mid_sep();
        int sep_j;
        sep_j = (T_LOAD + T_LYSIS + 6 * MC + T_BEADS) * TD;
        repeat (2) @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (sep_j + 1) @(negedge clk);
        chk("sep_outputs", obs_s, tup(5, 3'b111));
        #1 rst = 1'b1;
        #1;
        chk("rst_async_state", bus.state, 0);
        chk("rst_async_lines", obs_s[13:0], 14'h3FFF);
        chk("rst_async_busy", bus.busy, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_resume_state", bus.state, 0);
        chk("no_resume_lines", obs_s[13:0], 14'h3FFF);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("restart_state", bus.state, 1);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (3) @(negedge clk);
        chk("lines_during_rst", obs_s[13:0], 14'h3FFF);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("idle_state", bus.state, 0);
        chk("idle_lines", obs_s[13:0], 14'h3FFF);
        chk("idle_busy", bus.busy, 0);
        chk("idle_done", bus.done, 0);

        prev_obs = tup(0, 3'b111);
        have_cur = 1'b0;
        mon_en = 1'b1;
        for (int r = 0; r < 14; r++) run_one(r);
        repeat (5) @(negedge clk);
        mon_en = 1'b0;
        chk("queue_drained", exp_q.size(), 0);
        chk("done_pulses", n_done_seen, n_done_exp);
        chk("final_idle", obs_s, tup(0, 3'b111));

        reset_mid_sep();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
